memory_access: RTL
==================

# memory_access

Fourth pipeline stage of the MIPS core, directly downstream of `execute`. Consumes the EX/MEM register outputs and holds the data memory. Performs byte/half/word loads and stores and resolves conditional branches. Carries the MEM/WB pipeline register that feeds write-back and the forwarding paths.

## Interface
Parameters:
- `len`, 32: datapath width.
- `NB`, `$clog2(len)`: register index width.
- `len_mem_bus`, 9: memory control bus width.
- `len_wb_bus`, 2: write-back control bus width.
- `ram_depth`, 256: data memory depth in 32-bit words; must be a power of two.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_pc_branch` in `len`: branch target from EX/MEM.
- `in_alu` in `len`: ALU result, used as byte address for loads/stores.
- `zero_flag` in 1: ALU zero flag from EX/MEM.
- `in_reg2` in `len`: store data.
- `in_write_reg` in `NB`: destination register.
- `memory_bus` in `len_mem_bus`: bit 0 mem_read; bit 1 mem_write; bits 3:2 size (00 byte, 01 half, 11 word, 10 treated as word); bit 4 unsigned load; bit 5 branch_eq; bit 6 branch_ne; bits 8:7 reserved, ignored.
- `writeBack_bus` in `len_wb_bus`: bit 1 reg_write; bit 0 mem_to_reg. Passed through.
- `halt_flag_m` in 1: halt token from EX/MEM.
- `debug_addr` in `$clog2(ram_depth)`: word index for the debug-unit memory dump.
- `pc_src` out 1: combinational; equals (branch_eq & zero_flag) | (branch_ne & ~zero_flag).
- `out_pc_branch` out `len`: combinational copy of `in_pc_branch`, sent to fetch.
- `out_mem_data` out `len`: load result, extended.
- `out_alu` out `len`: registered `in_alu`.
- `out_write_reg` out `NB`: registered `in_write_reg`.
- `writeBack_bus_out` out `len_wb_bus`: registered `writeBack_bus`.
- `out_halt_flag_m` out 1: registered `halt_flag_m`.
- `misalign_err` out 1: sticky error flag.
- `debug_data` out `len`: word at `debug_addr`, one-cycle latency.

## Operation
- Word index = `in_alu[$clog2(ram_depth)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Lane offset = `in_alu[1:0]`.
- Store, with `mem_write` = 1 and the access aligned:
  - byte: writes lane `in_alu[1:0]` with `in_reg2[7:0]`;
  - half: writes lanes {1:0} or {3:2} with `in_reg2[15:0]`;
  - word: writes all four lanes.
  - Lane 0 = bits 7:0 (little-endian).
- Load, with `mem_read` = 1 and the access aligned: selects the lane(s), then zero-extends if unsigned = 1, otherwise sign-extends.
- Misaligned accesses: half with `in_alu[0]` = 1, or word with `in_alu[1:0]` ≠ 0.
  - The write is suppressed and the load returns 0.
  - `misalign_err` sets and stays set until reset.
- `mem_read` and `mem_write` both 1: the store is performed; the load returns the pre-store word (read-first).
- Neither set: `out_mem_data` = 0.
- RAM contents are not cleared by reset; they initialise to 0 at configuration.
- The debug port is an independent read port, active every cycle, including while halted.

## Timing
- `pc_src` and `out_pc_branch`: zero latency, combinational from inputs. Hazard/fetch logic uses them to flush IF/ID/EX in the same cycle.
- All other outputs: exactly one cycle latency.
- `out_mem_data` is derived combinationally from the synchronous RAM read word plus the registered lane offset, size and unsigned bits. It is stable for the whole following cycle.
- Store in cycle N, load of the same address in cycle N+1: the load returns the new data.
- While `reset` is high:
  - all outputs and registers are 0, including `pc_src` (the gated bus is treated as 0);
  - RAM writes are suppressed.
- Deassertion takes effect at the next rising edge.
- Reset asserted mid-cycle while a store is pending: the store is not performed.
- A flushed EX/MEM bubble (all-zero buses) produces no access, no branch and no write-back.

## Structure
- Shared package `mips_pkg`:
  - memory-bus bit index constants (`MEM_READ`, `MEM_WRITE`, `MEM_SIZE_LSB/MSB`, `MEM_UNSIGNED`, `BR_EQ`, `BR_NE`);
  - write-back bus indices (`WB_REG_WRITE`, `WB_MEM_TO_REG`);
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`).
- Sub-module `data_memory`: dual-port byte-lane-enable RAM. Port A is read/write, read-first. Port B is read-only, for debug. Inferable as block RAM.
- The top handles alignment, lane steering, extension, branch resolution and the MEM/WB register.

## Test plan
- Reset mid-store: assert `reset` during a word store to 0x0 while `writeBack_bus` = 2'b10 -> all outputs 0 while `reset` is high; a later load of 0x0 returns 0x0000_0000.
- Store/load: word store 0x8081_82F3 @0x10, then:
  - lb @0x10 -> 0xFFFF_FFF3;
  - lbu @0x13 -> 0x0000_0080;
  - lh @0x12 -> 0xFFFF_8081;
  - lhu @0x10 -> 0x0000_82F3.
- Byte/half stores: sb 0xAA @0x21, then sh 0xBEEF @0x22 onto a zeroed word -> lw @0x20 = 0xBEEF_AA00; `debug_addr` = 8 -> `debug_data` = 0xBEEF_AA00 one cycle later.
- Branch: branch_eq with `zero_flag` = 1 -> `pc_src` = 1 same cycle, `out_pc_branch` = `in_pc_branch`. branch_ne with `zero_flag` = 1 -> `pc_src` = 0. Bubble -> `pc_src` = 0.
- Misaligned: sw @0x22 -> no RAM change, `misalign_err` = 1 and stays 1 across later aligned ops; lh @0x05 -> `out_mem_data` = 0.
- Wrap/pass-through: lw @(`ram_depth`·4 + 0x10) returns the word at 0x10. `halt_flag_m`, `writeBack_bus` = 2'b11 and `in_write_reg` = 5'd31 all appear registered one cycle later.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: control-bus field positions, access-size encodings and lane helpers shared by the pipeline stages.
package mips_pkg;
  localparam int MEM_READ = 0;
  localparam int MEM_WRITE = 1;
  localparam int MEM_SIZE_LSB = 2;
  localparam int MEM_SIZE_MSB = 3;
  localparam int MEM_UNSIGNED = 4;
  localparam int BR_EQ = 5;
  localparam int BR_NE = 6;
  localparam int WB_REG_WRITE = 1;
  localparam int WB_MEM_TO_REG = 0;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;
  // Any size with bit 1 set behaves as a word, so 2'b10 aliases SZ_WORD.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    return sz == SZ_HALF ? off[0] : sz[1] ? |off : 1'b0;
  endfunction
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    return sz == SZ_BYTE ? 4'b0001 << off : sz == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/data_memory.sv
// data_memory: dual-port byte-enable RAM; port A read-first read/write, port B read-only for debug dumps.
module data_memory #(
  parameter int width = 32,
  parameter int depth = 256,
  parameter int aw = $clog2(depth)
) (
  input  logic                 clk,
  input  logic [aw-1:0]        addr_a,
  input  logic [width/8-1:0]   we_a,
  input  logic [width-1:0]     wdata_a,
  output logic [width-1:0]     rdata_a,
  input  logic [aw-1:0]        addr_b,
  output logic [width-1:0]     rdata_b
);
  logic [width-1:0] mem [depth];
  always_ff @(posedge clk) begin
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
    for (int i = 0; i < width / 8; i++)
      if (we_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
  end
endmodule

// File: rtl/memory_access.sv
// memory_access: MEM stage - byte/half/word loads and stores, branch resolution and the MEM/WB register.
module memory_access
  import mips_pkg::*;
#(
  parameter int len = 32,
  parameter int NB = $clog2(len),
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus = 2,
  parameter int ram_depth = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [len-1:0]               in_pc_branch,
  input  logic [len-1:0]               in_alu,
  input  logic                         zero_flag,
  input  logic [len-1:0]               in_reg2,
  input  logic [NB-1:0]                in_write_reg,
  input  logic [len_mem_bus-1:0]       memory_bus,
  input  logic [len_wb_bus-1:0]        writeBack_bus,
  input  logic                         halt_flag_m,
  input  logic [$clog2(ram_depth)-1:0] debug_addr,
  output logic                         pc_src,
  output logic [len-1:0]               out_pc_branch,
  output logic [len-1:0]               out_mem_data,
  output logic [len-1:0]               out_alu,
  output logic [NB-1:0]                out_write_reg,
  output logic [len_wb_bus-1:0]        writeBack_bus_out,
  output logic                         out_halt_flag_m,
  output logic                         misalign_err,
  output logic [len-1:0]               debug_data
);
  localparam int AW = $clog2(ram_depth);
  logic [len_mem_bus-1:0] bus;
  logic [1:0] sz, off, sz_q, off_q;
  logic rd, wr, mis, ld_q, uns_q;
  logic [3:0] we;
  logic [len-1:0] wdata, ram_q, dbg_q;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic unused;
  // Reset gates the whole control bus so no access or branch escapes during reset.
  assign bus = reset ? '0 : memory_bus;
  assign rd = bus[MEM_READ];
  assign wr = bus[MEM_WRITE];
  assign sz = bus[MEM_SIZE_MSB:MEM_SIZE_LSB];
  assign off = in_alu[1:0];
  assign mis = (rd | wr) & misaligned(sz, off);
  assign we = (wr & ~mis) ? lane_mask(sz, off) : 4'b0000;
  assign wdata = sz == SZ_BYTE ? {4{in_reg2[7:0]}} : sz == SZ_HALF ? {2{in_reg2[15:0]}} : in_reg2;
  assign pc_src = (bus[BR_EQ] & zero_flag) | (bus[BR_NE] & ~zero_flag);
  assign out_pc_branch = reset ? '0 : in_pc_branch;
  assign debug_data = reset ? '0 : dbg_q;
  assign unused = ^{memory_bus[len_mem_bus-1:BR_NE+1], in_alu[len-1:AW+2]};
  data_memory #(.width(len), .depth(ram_depth)) u_mem (
    .clk(clk), .addr_a(in_alu[AW+1:2]), .we_a(we), .wdata_a(wdata), .rdata_a(ram_q),
    .addr_b(debug_addr), .rdata_b(dbg_q)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_q <= 1'b0;
      uns_q <= 1'b0;
      sz_q <= '0;
      off_q <= '0;
      out_alu <= '0;
      out_write_reg <= '0;
      writeBack_bus_out <= '0;
      out_halt_flag_m <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      ld_q <= rd & ~mis;
      uns_q <= bus[MEM_UNSIGNED];
      sz_q <= sz;
      off_q <= off;
      out_alu <= in_alu;
      out_write_reg <= in_write_reg;
      writeBack_bus_out <= writeBack_bus;
      out_halt_flag_m <= halt_flag_m;
      misalign_err <= misalign_err | mis;
    end
  end
  always_comb begin
    byte_v = ram_q[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? ram_q[31:16] : ram_q[15:0];
    out_mem_data = !ld_q ? '0
                 : sz_q == SZ_BYTE ? {{(len-8){~uns_q & byte_v[7]}}, byte_v}
                 : sz_q == SZ_HALF ? {{(len-16){~uns_q & half_v[15]}}, half_v}
                 : ram_q;
  end
endmodule
